// File: rtl/alu_accumulator_pkg.sv
// Shared opcode map, flag bit positions and instruction-group masks for the
// ALU/accumulator stage.
package alu_accumulator_pkg;

    // Flag bit positions inside Flags = {OV, NEG, CARRY, ZERO}
    localparam int ZERO  = 0;
    localparam int CARRY = 1;
    localparam int NEG   = 2;
    localparam int OV    = 3;

    // Group decode: IR[7:6] picks the group, IR[5:3] must be zero,
    // IR[2] picks the operand (0 = MBR, 1 = IBR), IR[1:0] picks the function.
    localparam logic [7:0] GRP_MASK  = 8'hF8;
    localparam logic [7:0] ARITH_GRP = 8'h40;
    localparam logic [7:0] LOGIC_GRP = 8'h80;
    localparam logic [7:0] SRC_MASK  = 8'h04;

    // Data movement (load/store X and I share one encoding apart from IR[2])
    localparam logic [7:0] LOAD_X  = 8'h01;
    localparam logic [7:0] LOAD_I  = 8'h05;
    localparam logic [7:0] STORE_X = 8'h02;
    localparam logic [7:0] STORE_I = 8'h06;

    // Control flow, resolved by the FSM from Flags
    localparam logic [7:0] JMP = 8'hC0;
    localparam logic [7:0] JZ  = 8'hC1;
    localparam logic [7:0] JC  = 8'hC2;
    localparam logic [7:0] JN  = 8'hC3;
    localparam logic [7:0] JV  = 8'hC4;

    // Arithmetic group
    localparam logic [7:0] ADD_X  = 8'h40;
    localparam logic [7:0] SUB_X  = 8'h41;
    localparam logic [7:0] ADDC_X = 8'h42;
    localparam logic [7:0] SUBC_X = 8'h43;
    localparam logic [7:0] ADD_I  = 8'h44;
    localparam logic [7:0] SUB_I  = 8'h45;
    localparam logic [7:0] ADDC_I = 8'h46;
    localparam logic [7:0] SUBC_I = 8'h47;

    // Logic group
    localparam logic [7:0] NOR_X  = 8'h80;
    localparam logic [7:0] NAND_X = 8'h81;
    localparam logic [7:0] XOR_X  = 8'h82;
    localparam logic [7:0] XNOR_X = 8'h83;
    localparam logic [7:0] NOR_I  = 8'h84;
    localparam logic [7:0] NAND_I = 8'h85;
    localparam logic [7:0] XOR_I  = 8'h86;
    localparam logic [7:0] XNOR_I = 8'h87;

    typedef enum logic [1:0] {
        FN_ADD  = 2'b00,
        FN_SUB  = 2'b01,
        FN_ADDC = 2'b10,
        FN_SUBC = 2'b11
    } arith_fn_e;

    typedef enum logic [1:0] {
        FN_NOR  = 2'b00,
        FN_NAND = 2'b01,
        FN_XOR  = 2'b10,
        FN_XNOR = 2'b11
    } logic_fn_e;

endpackage

// File: rtl/alu_accumulator_core.sv
// Combinational ALU: decodes IR, computes the result and new flag values, and
// reports which architectural fields the instruction is allowed to write.
module alu_core
    import alu_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] op,
    input  logic                  cin,
    input  logic [INST_WIDTH-1:0] IR,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  c,
    output logic                  v,
    output logic                  z,
    output logic                  n,
    output logic                  wr_ar,
    output logic                  wr_c,
    output logic                  wr_v,
    output logic                  wr_zn
);

    logic [7:0]            opc;
    logic [DATA_WIDTH-1:0] b;
    logic                  ci;
    logic [DATA_WIDTH:0]   sum;

    assign opc = IR[7:0];

    // Subtraction forms add the inverted operand; the carry-in comes from the
    // function code (0 for ADD, 1 for SUB, stored carry for ADDC/SUBC).
    assign b   = opc[0] ? ~op : op;
    assign ci  = (arith_fn_e'(opc[1:0]) == FN_ADD) ? 1'b0 :
                 (arith_fn_e'(opc[1:0]) == FN_SUB) ? 1'b1 : cin;
    assign sum = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, ci};

    // Group decode, result select and write-enable generation
    always_comb begin
        result = a;
        c      = cin;
        v      = 1'b0;
        wr_ar  = 1'b0;
        wr_c   = 1'b0;
        wr_v   = 1'b0;
        wr_zn  = 1'b0;
        if ((opc & GRP_MASK) == ARITH_GRP) begin
            result = sum[DATA_WIDTH-1:0];
            c      = sum[DATA_WIDTH];
            v      = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                     (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            wr_ar  = 1'b1;
            wr_c   = 1'b1;
            wr_v   = 1'b1;
            wr_zn  = 1'b1;
        end else if ((opc & GRP_MASK) == LOGIC_GRP) begin
            unique case (logic_fn_e'(opc[1:0]))
                FN_NOR:  result = ~(a | op);
                FN_NAND: result = ~(a & op);
                FN_XOR:  result = a ^ op;
                FN_XNOR: result = ~(a ^ op);
            endcase
            wr_ar = 1'b1;
            wr_v  = 1'b1;
            wr_zn = 1'b1;
        end else if ((opc & ~SRC_MASK) == LOAD_X) begin
            result = op;
            wr_ar  = 1'b1;
            wr_zn  = 1'b1;
        end
    end

    assign z = (result == '0);
    assign n = result[DATA_WIDTH-1];

endmodule

// File: rtl/alu_accumulator.sv
// Registered accumulator stage: holds AR, Flags and the done strobe, and
// commits the ALU result on each Exec strobe.
module alu_accumulator
    import alu_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Exec,
    input  logic [INST_WIDTH-1:0] IR,
    input  logic [DATA_WIDTH-1:0] IBR,
    input  logic [DATA_WIDTH-1:0] MBR,
    output logic [DATA_WIDTH-1:0] AR,
    output logic [3:0]            Flags,
    output logic                  done
);

    logic [DATA_WIDTH-1:0] ar_q, ar_d;
    logic [3:0]            flags_q, flags_d;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] op, result;
    logic                  c, v, z, n;
    logic                  wr_ar, wr_c, wr_v, wr_zn;

    assign op = IR[2] ? IBR : MBR;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_core (
        .a      (ar_q),
        .op     (op),
        .cin    (flags_q[CARRY]),
        .IR     (IR),
        .result (result),
        .c      (c),
        .v      (v),
        .z      (z),
        .n      (n),
        .wr_ar  (wr_ar),
        .wr_c   (wr_c),
        .wr_v   (wr_v),
        .wr_zn  (wr_zn)
    );

    // Next-state: only fields the instruction owns change, and only on Exec
    always_comb begin
        ar_d    = ar_q;
        flags_d = flags_q;
        if (Exec) begin
            if (wr_ar) ar_d = result;
            if (wr_c)  flags_d[CARRY] = c;
            if (wr_v)  flags_d[OV]    = v;
            if (wr_zn) begin
                flags_d[ZERO] = z;
                flags_d[NEG]  = n;
            end
        end
    end

    // State registers; reset wins over a coincident Exec
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            ar_q    <= ar_d;
            flags_q <= flags_d;
            done_q  <= Exec;
        end
    end

    assign AR    = ar_q;
    assign Flags = flags_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator: a table of single-Exec vectors followed
// by hand-written back-to-back, idle-hold and reset-collision sequences.
module tb_alu_accumulator;
    import alu_accumulator_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Exec;
    logic [7:0] IR, IBR, MBR;
    logic [7:0] AR;
    logic [3:0] Flags;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_accumulator #(.DATA_WIDTH(8), .INST_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Exec  (Exec),
        .IR    (IR),
        .IBR   (IBR),
        .MBR   (MBR),
        .AR    (AR),
        .Flags (Flags),
        .done  (done)
    );

    typedef struct {
        logic [7:0] ir;
        logic [7:0] ibr;
        logic [7:0] mbr;
        logic [7:0] exp_ar;
        logic [3:0] exp_fl;   // {V, N, C, Z}
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive one instruction for exactly one cycle; sample #1 after the edge
    task automatic exec_one(input logic [7:0] ir, input logic [7:0] ibr, input logic [7:0] mbr);
        @(negedge clk);
        IR = ir; IBR = ibr; MBR = mbr; Exec = 1'b1;
        @(posedge clk);
        #1;
        Exec = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{LOAD_I, 8'h7F, 8'h00, 8'h7F, 4'h0};
        vecs[1]  = '{ADD_I,  8'h01, 8'h00, 8'h80, 4'hC};  // signed overflow
        vecs[2]  = '{LOAD_I, 8'h05, 8'h00, 8'h05, 4'h8};  // C,V kept
        vecs[3]  = '{SUB_X,  8'h00, 8'h05, 8'h00, 4'h3};  // equal -> Z, no borrow
        vecs[4]  = '{LOAD_I, 8'hFF, 8'h00, 8'hFF, 4'h6};
        vecs[5]  = '{ADDC_I, 8'h00, 8'h00, 8'h00, 4'h3};  // FF+0+1 wraps
        vecs[6]  = '{ADDC_I, 8'h00, 8'h00, 8'h01, 4'h0};
        vecs[7]  = '{ADD_I,  8'hFF, 8'h00, 8'h00, 4'h3};  // 01+FF sets C
        vecs[8]  = '{LOAD_I, 8'hAA, 8'h00, 8'hAA, 4'h6};
        vecs[9]  = '{XOR_X,  8'h00, 8'hFF, 8'h55, 4'h2};  // C kept
        vecs[10] = '{NOR_I,  8'h0F, 8'h00, 8'hA0, 4'h6};
        vecs[11] = '{NAND_X, 8'h00, 8'hF0, 8'h5F, 4'h2};
        vecs[12] = '{XNOR_I, 8'h5F, 8'h00, 8'hFF, 4'h6};
        vecs[13] = '{SUB_I,  8'h01, 8'h00, 8'hFE, 4'h6};
        vecs[14] = '{SUBC_X, 8'h00, 8'h7F, 8'h7F, 4'hA};  // neg - pos overflows
        vecs[15] = '{JZ,     8'h12, 8'h34, 8'h7F, 4'hA};
        vecs[16] = '{STORE_X,8'h56, 8'h78, 8'h7F, 4'hA};
        vecs[17] = '{8'hFF,  8'h00, 8'h00, 8'h7F, 4'hA};  // undefined encoding
        vecs[18] = '{LOAD_X, 8'h99, 8'h00, 8'h00, 4'hB};
        vecs[19] = '{ADD_X,  8'h00, 8'h7F, 8'h7F, 4'h0};

        rst_n = 1'b0; Exec = 1'b0; IR = 8'h00; IBR = 8'h00; MBR = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ar",    AR,            8'h00);
        chk("reset_flags", {4'h0, Flags}, 8'h00);
        chk("reset_done",  {7'h0, done},  8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one Exec each, then an idle cycle to confirm done drops
        for (int i = 0; i < 20; i++) begin
            exec_one(vecs[i].ir, vecs[i].ibr, vecs[i].mbr);
            chk($sformatf("v%0d_ar", i),    AR,                   vecs[i].exp_ar);
            chk($sformatf("v%0d_flags", i), {4'h0, Flags},        {4'h0, vecs[i].exp_fl});
            chk($sformatf("v%0d_done", i),  {7'h0, done},         8'h01);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_low", i), {7'h0, done}, 8'h00);
        end

        // Back-to-back carry chain: LOAD FF, ADD 01, LOAD FF, ADDC 00, ADDC 00
        exec_one(LOAD_I, 8'hFF, 8'h00);
        @(negedge clk); IR = ADD_I;  IBR = 8'h01; Exec = 1'b1;
        @(posedge clk); #1;
        chk("b2b_wrap_ar",    AR,            8'h00);
        chk("b2b_wrap_flags", {4'h0, Flags}, 8'h03);
        chk("b2b_wrap_done",  {7'h0, done},  8'h01);
        @(negedge clk); IR = LOAD_I; IBR = 8'hFF;
        @(posedge clk); #1;
        chk("b2b_load_flags", {4'h0, Flags}, 8'h06);
        @(negedge clk); IR = ADDC_I; IBR = 8'h00;
        @(posedge clk); #1;
        chk("b2b_addc1_ar",    AR,            8'h00);
        chk("b2b_addc1_flags", {4'h0, Flags}, 8'h03);
        @(negedge clk);
        @(posedge clk); #1;
        chk("b2b_addc2_ar",    AR,            8'h01);
        chk("b2b_addc2_flags", {4'h0, Flags}, 8'h00);
        chk("b2b_addc2_done",  {7'h0, done},  8'h01);
        @(negedge clk); Exec = 1'b0;
        @(posedge clk); #1;
        chk("b2b_done_low", {7'h0, done}, 8'h00);

        // Idle: inputs churn with Exec low, outputs must hold AR=01, Flags=0
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            IR = 8'($urandom); IBR = 8'($urandom); MBR = 8'($urandom);
            @(posedge clk); #1;
            chk($sformatf("idle%0d_ar", i),    AR,                            8'h01);
            chk($sformatf("idle%0d_fd", i),    {3'h0, done, Flags},           8'h00);
        end

        // Reset collides with an Exec: instruction discarded
        exec_one(LOAD_I, 8'h20, 8'h00);
        chk("pre_rst_ar", AR, 8'h20);
        @(negedge clk);
        IR = ADD_I; IBR = 8'h10; Exec = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        Exec = 1'b0;
        chk("rst_exec_ar",    AR,            8'h00);
        chk("rst_exec_flags", {4'h0, Flags}, 8'h00);
        chk("rst_exec_done",  {7'h0, done},  8'h00);
        @(negedge clk); rst_n = 1'b1;
        exec_one(LOAD_I, 8'h80, 8'h00);
        chk("post_rst_ar",    AR,            8'h80);
        chk("post_rst_flags", {4'h0, Flags}, 8'h04);
        chk("post_rst_done",  {7'h0, done},  8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
